// File: rtl/mult_issue_ctrl.sv
`default_nettype none
// ============================================================================
// mult_issue_ctrl: operand FIFO plus load/wait/hold sequencer for a
// fixed-latency shift-add multiplier, with a valid/ready result port.
// Revision: 1.0
// ============================================================================
module mult_issue_ctrl #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4,
    parameter int LAT   = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic                     mul_load,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    input  logic [2*WIDTH-1:0]       mul_product,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*WIDTH-1:0]       out_product,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] WAIT_INIT  = CW'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  mem_a [DEPTH];
    logic [WIDTH-1:0]  mem_b [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     wait_cnt;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    assign full     = (fifo_count == FULL_COUNT);
    assign empty    = (fifo_count == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    // The head is consumed during the single LOAD cycle; LOAD is only entered with a non-empty FIFO.
    assign pop      = (state == LOAD);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            mul_load    <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            out_valid   <= 1'b0;
            out_product <= '0;
            wait_cnt    <= '0;
        end else begin
            mul_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state    <= LOAD;
                        mul_load <= 1'b1;
                        mul_a    <= mem_a[rd_ptr];
                        mul_b    <= mem_b[rd_ptr];
                    end
                end
                LOAD: begin
                    state    <= WAIT;
                    wait_cnt <= WAIT_INIT;
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        out_product <= mul_product;
                        out_valid   <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (!empty) begin
                            state    <= LOAD;
                            mul_load <= 1'b1;
                            mul_a    <= mem_a[rd_ptr];
                            mul_b    <= mem_b[rd_ptr];
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mult_issue_ctrl.md
Name: mult_issue_ctrl

Overview:
Sequencing front-end for the 6x6 shift-add multiplier (clk, reset, load, a, b, product[11:0]).
- Buffers operand pairs from a producer in a small FIFO.
- Issues one load pulse per pair and waits the multiplier's fixed iteration latency.
- Captures the 12-bit product and presents it downstream on a valid/ready handshake.
- Sits directly upstream and downstream of the multiplier: feeds its operands and consumes its product.

Parameters:
- WIDTH, 6, operand width; product width is 2*WIDTH.
- DEPTH, 4, operand FIFO entries (power of two, >=2).
- LAT, 6, cycles after the load cycle until mul_product is valid (>=1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 clears all state immediately).
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO can accept; equals !full.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- mul_load  out  1  one-cycle load pulse to the multiplier.
- mul_a  out  WIDTH  registered operand a to the multiplier.
- mul_b  out  WIDTH  registered operand b to the multiplier.
- mul_product  in  2*WIDTH  multiplier result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_product  out  2*WIDTH  captured product.
- fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, FIFO empty, fifo_count=0.
  - mul_load=0, mul_a=0, mul_b=0.
  - out_valid=0, out_product=0, busy=0, in_ready=1.
  - An in-flight multiplication is discarded; no result is ever emitted for it.
- Push: FIFO is written on in_valid && in_ready.
  - in_ready depends only on the registered full flag; there is no bypass.
  - A push offered while full is ignored, even in the same cycle as a pop.
- FIFO pointers wrap modulo DEPTH.
- Simultaneous push and pop leaves fifo_count unchanged.
- FSM states: IDLE, LOAD, WAIT, HOLD.
  - IDLE: if FIFO non-empty, go to LOAD next cycle. mul_a/mul_b are loaded from the FIFO head on that same edge.
  - LOAD (exactly 1 cycle): mul_load=1 and the FIFO head is popped. Next state WAIT, wait counter=LAT-1.
  - WAIT: mul_load=0; the counter decrements each cycle.
    - When counter==0: out_product<=mul_product, out_valid<=1, next state HOLD.
    - WAIT therefore lasts exactly LAT cycles.
  - HOLD: out_valid=1 and out_product are stable until out_ready.
    - On out_valid && out_ready: out_valid<=0.
    - Next state is LOAD if the FIFO is non-empty (load mul_a/mul_b from head on this edge), else IDLE.
- mul_a/mul_b stay constant from the entry into LOAD until the next LOAD.
- Latency:
  - Push into an empty idle block at edge t gives mul_load high in cycle t+2.
  - out_valid rises LAT+1 edges after the LOAD cycle begins.
- Throughput with out_ready held 1: one result every LAT+2 cycles.
- Back-pressure: with out_ready=0 the block holds in HOLD indefinitely while the FIFO keeps accepting until full.
- Products are full 2*WIDTH unsigned; there is no truncation or overflow.
- Result order equals push order.

Test Plan:
Bench uses a behavioural multiplier model returning a*b exactly LAT cycles after the load cycle, and X otherwise.
- Single op: push (5,6), out_ready=1. mul_load pulses once; 7 cycles later (LAT+1 edges after the LOAD cycle begins) out_valid=1 with out_product=12'h01E; then IDLE, busy=0.
- Boundary operands: push (63,63), (0,45), (1,63) back-to-back. Outputs are 3969 (12'hF81), 0, 63 in order, spaced LAT+2 cycles apart.
- Back-pressure: out_ready=0, push 6 pairs on consecutive cycles.
  - Exactly 5 are accepted (1 issued, 4 buffered); fifo_count=4 and in_ready=0; the 6th is held off.
  - Raising out_ready drains all 5 results in order.
- Full with push and pop in the same cycle: with FIFO full, hold in_valid=1 through the HOLD->LOAD pop. The push is refused that cycle and accepted the next cycle; fifo_count goes 4->3->4.
- Reset mid-operation: assert reset=0 during WAIT, asynchronously between edges.
  - Immediately: out_valid=0, mul_load=0, fifo_count=0.
  - After release, no stale result appears; a fresh push (7,9) yields 63.
- Hold stability: in HOLD with out_ready=0 for 20 cycles, out_product and out_valid do not change while mul_product is driven to X.
